// File: rtl/CLA_4BIT.sv
// rtl/CLA_4BIT.sv - 4-bit carry-lookahead adder
// Carries are formed directly from generate/propagate terms, so there is no ripple chain.
module CLA_4BIT (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/seq_mult_4bit.sv
// rtl/seq_mult_4bit.sv - sequential 4x4 unsigned shift-and-add multiplier
// One CLA_4BIT addition per clock; the 9-bit {carry,sum,Q} is shifted right each iteration.
module seq_mult_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;

  logic [3:0] addend;
  logic [3:0] add_sum;
  logic       add_cout;

  assign addend = q_q[0] ? m_q : 4'b0000;

  CLA_4BIT u_cla (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .s    (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = 4'b0000;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end

      RUN: begin
        // The carry lands in acc[3]; dropping it breaks 15x15.
        {acc_d, q_d} = {add_cout, add_sum, q_q[3:1]};
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = {add_cout, add_sum, q_q[3:1]};
          state_d   = DONE;
        end
      end

      DONE: begin
        // Accepting on the edge that leaves DONE gives one result every 5 clocks.
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = 4'b0000;
          cnt_d   = 2'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= 4'b0000;
      q_q       <= 4'b0000;
      acc_q     <= 4'b0000;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_4bit.sv
// tb/tb_seq_mult_4bit.sv - directed self-checking bench for seq_mult_4bit
// Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
module tb_seq_mult_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int errors;
  int checks;

  seq_mult_4bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (product !== 8'h00) begin
        errors++;
        $display("FAIL reset_product cycle %0d: got %h want 00", i, product);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy cycle %0d: got %b want 0", i, busy);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_done cycle %0d: got %b want 0", i, done);
      end
    end
  endtask

  // One full operation from IDLE: 4 busy cycles, one done cycle, then product holds.
  task automatic run_mult(input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] exp, input string name);
    int n;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    n     = 0;
    while (busy === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d want 4", name, n);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got %b want 1", name, done);
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s_product: got %h want %h", name, product, exp);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_fall: got %b want 0", name, done);
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s_product_hold: got %h want %h", name, product, exp);
    end
  endtask

  task automatic test_basic();
    run_mult(4'd13, 4'd11, 8'h8F, "basic_13x11");
    repeat (3) @(negedge clk);
    checks++;
    if (product !== 8'h8F) begin
      errors++;
      $display("FAIL basic_hold_idle: got %h want 8f", product);
    end
  endtask

  task automatic test_carry();
    run_mult(4'd15, 4'd15, 8'hE1, "carry_15x15");
    run_mult(4'd0,  4'd9,  8'h00, "zero_0x9");
    run_mult(4'd1,  4'd15, 8'h0F, "one_1x15");
  endtask

  task automatic test_ignored_start();
    int dones;
    a     = 4'd3;
    b     = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 4'd7;
    b     = 4'd7;
    @(negedge clk);
    start = 1'b0;
    a     = 4'd15;
    b     = 4'd15;
    @(negedge clk);
    checks++;
    if (product !== 8'h0F) begin
      errors++;
      $display("FAIL ign_product_stable_busy: got %h want 0f (previous)", product);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || product !== 8'h0F) begin
      errors++;
      $display("FAIL ign_result: got done=%b product=%h want done=1 product=0f", done, product);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL ign_no_second_op: got %0d active cycles want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    a     = 4'd2;
    b     = 4'd3;
    start = 1'b1;
    @(negedge clk);
    a = 4'd4;
    b = 4'd4;
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || product !== 8'h06) begin
      errors++;
      $display("FAIL b2b_first: got done=%b product=%h want done=1 product=06", done, product);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (product !== 8'h06) begin
      errors++;
      $display("FAIL b2b_product_stable: got %h want 06", product);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_early_done: got %b want 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || product !== 8'h10) begin
      errors++;
      $display("FAIL b2b_second: got done=%b product=%h want done=1 product=10", done, product);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_after: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    a     = 4'd9;
    b     = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (product !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got product=%h busy=%b done=%b want 00 0 0", product, busy, done);
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d active cycles want 0", dones);
    end
    run_mult(4'd9, 4'd9, 8'h51, "midrst_9x9");
  endtask

  task automatic test_start_with_reset();
    a     = 4'd5;
    b     = 4'd5;
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || product !== 8'h00) begin
      errors++;
      $display("FAIL rst_start: got busy=%b product=%h want 0 00", busy, product);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_dropped: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_carry();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    test_start_with_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
